// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single memory port of the multi-cycle core between the core
// (fetch/load/store) and the debug/program-loader port. One transaction is in
// flight at a time. Ties are broken round-robin against the last granted
// requester. The fixed memory read latency is timed with a small down-counter.
// Misaligned or illegal-size requests are granted and answered with err
// without ever strobing the memory.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   core_req/we/size/addr/wdata   core request (held until core_gnt)
//   core_gnt/done/err/rdata       core responses (one-cycle gnt/done pulses)
//   dbg_*                         same set for the debug requester
//   mem_en/we/size/addr/wdata     memory command, valid while mem_en=1
//   mem_rdata                     read data, MEM_LATENCY cycles after mem_en
//   owner                         0=core, 1=dbg; current/last granted requester
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [1:0]            core_size,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_gnt,
    output logic                  core_done,
    output logic                  core_err,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [1:0]            dbg_size,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_done,
    output logic                  dbg_err,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // WAIT is entered with this count and leaves when it reaches zero, so
    // WAIT lasts exactly MEM_LATENCY cycles.
    localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

    state_t                state_reg, state_next;
    logic [1:0]            cnt_reg, cnt_next;
    logic                  owner_reg;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] rdata_reg [2];

    // Requesters packed by index: 0=core, 1=dbg (same encoding as owner).
    logic [1:0]            req_vec;
    logic [1:0]            we_vec;
    logic [1:0]            size_vec  [2];
    logic [ADDR_WIDTH-1:0] addr_vec  [2];
    logic [DATA_WIDTH-1:0] wdata_vec [2];

    assign req_vec      = {dbg_req, core_req};
    assign we_vec       = {dbg_we, core_we};
    assign size_vec[0]  = core_size;
    assign size_vec[1]  = dbg_size;
    assign addr_vec[0]  = core_addr;
    assign addr_vec[1]  = dbg_addr;
    assign wdata_vec[0] = core_wdata;
    assign wdata_vec[1] = dbg_wdata;

    logic winner;
    logic misaligned;
    logic load;
    logic capture;

    // Sole requester wins; on a tie the one that was not granted last wins.
    always_comb begin
        winner = req_vec[1];
        if (req_vec[0] && req_vec[1]) begin
            winner = ~owner_reg;
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (size_vec[winner])
            2'b01:   misaligned = addr_vec[winner][0];
            2'b10:   misaligned = |addr_vec[winner][1:0];
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    load       = 1'b1;
                    state_next = misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = LAT_M1;
            end
            WAIT: begin
                if (cnt_reg == 2'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            owner_reg <= 1'b1;
            we_reg    <= 1'b0;
            size_reg  <= 2'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load) begin
                owner_reg <= winner;
                we_reg    <= we_vec[winner];
                size_reg  <= size_vec[winner];
                addr_reg  <= addr_vec[winner];
                wdata_reg <= wdata_vec[winner];
                err_reg   <= misaligned;
            end
        end
    end

    // Read data lands on the last WAIT cycle; writes leave rdata untouched.
    assign capture = (state_reg == WAIT) && (cnt_reg == 2'd0) && !we_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg[gi] <= '0;
                end else if (capture && (owner_reg == 1'(gi))) begin
                    rdata_reg[gi] <= mem_rdata;
                end
            end
        end
    endgenerate

    // Response pulses; the misaligned path grants in its RESP cycle.
    logic issue;
    logic resp;
    logic gnt_pulse;

    assign issue     = (state_reg == ISSUE);
    assign resp      = (state_reg == RESP);
    assign gnt_pulse = issue | (resp & err_reg);

    assign core_gnt   = gnt_pulse & ~owner_reg;
    assign dbg_gnt    = gnt_pulse & owner_reg;
    assign core_done  = resp & ~owner_reg;
    assign dbg_done   = resp & owner_reg;
    assign core_err   = resp & err_reg & ~owner_reg;
    assign dbg_err    = resp & err_reg & owner_reg;
    assign core_rdata = rdata_reg[0];
    assign dbg_rdata  = rdata_reg[1];

    assign mem_en    = issue;
    assign mem_we    = issue & we_reg;
    assign mem_size  = issue ? size_reg : 2'd0;
    assign mem_addr  = issue ? addr_reg : '0;
    assign mem_wdata = issue ? wdata_reg : '0;

    assign owner = owner_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters: u_dut (MEM_LATENCY=1) carries the main vector table, the
// round-robin and mid-transaction reset sequences; u_dut3 (MEM_LATENCY=3)
// shares the request fields but has its own req lines and covers the longer
// latency. Each instance has a memory model that presents valid read data only
// in the cycle exactly MEM_LATENCY cycles after mem_en.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        core_req, core_we, dbg_req, dbg_we;
    logic [1:0]  core_size, dbg_size;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic        core_req3, dbg_req3;

    logic        core_gnt, core_done, core_err, dbg_gnt, dbg_done, dbg_err;
    logic [31:0] core_rdata, dbg_rdata;
    logic        mem_en, mem_we, owner;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        core_gnt_3, core_done_3, core_err_3, dbg_gnt_3, dbg_done_3, dbg_err_3;
    logic [31:0] core_rdata_3, dbg_rdata_3;
    logic        mem_en_3, mem_we_3, owner_3;
    logic [1:0]  mem_size_3;
    logic [31:0] mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [31:0] pipe3_a, pipe3_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mem_en_cnt = 0;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .core_req(core_req3), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt_3), .core_done(core_done_3), .core_err(core_err_3), .core_rdata(core_rdata_3),
        .dbg_req(dbg_req3), .dbg_we(dbg_we), .dbg_size(dbg_size),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt_3), .dbg_done(dbg_done_3), .dbg_err(dbg_err_3), .dbg_rdata(dbg_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_size(mem_size_3), .mem_addr(mem_addr_3),
        .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3), .owner(owner_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed word at 0x100, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_en_cnt <= mem_en_cnt + 1;
        mem_rdata   <= (mem_en && !mem_we) ? mem_f(mem_addr) : JUNK;
        pipe3_a     <= (mem_en_3 && !mem_we_3) ? mem_f(mem_addr_3) : JUNK;
        pipe3_b     <= pipe3_a;
        mem_rdata_3 <= pipe3_b;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        who;     // 0=core, 1=dbg
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;  // requester's rdata after the transaction
    } vec_t;

    typedef struct {
        logic        who;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    // Scoreboard and per-cycle invariants on the latency-1 instance.
    always @(negedge clk) begin
        if (!rst) begin
            chk("one_gnt", 32'(core_gnt & dbg_gnt), 32'd0);
            chk("one_done", 32'(core_done & dbg_done), 32'd0);
            chk("nonowner_quiet", 32'(owner ? (core_gnt | core_done | core_err)
                                            : (dbg_gnt | dbg_done | dbg_err)), 32'd0);
            chk("err_only_with_done", 32'((core_err & ~core_done) | (dbg_err & ~dbg_done)), 32'd0);
            chk("dut3_dbg_quiet", 32'(dbg_gnt_3 | dbg_done_3 | dbg_err_3) | dbg_rdata_3, 32'd0);
            if (core_done || dbg_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 32'(dbg_done), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_who", 32'(dbg_done), 32'(e.who));
                    chk("sb_err", 32'(e.who ? dbg_err : core_err), 32'(e.err));
                    chk("sb_rdata", e.who ? dbg_rdata : core_rdata, e.rdata);
                end
            end
        end
    end

    task automatic drive_req(input vec_t v, input logic req);
        // After the grant the fields are scrambled: the latched copy must win.
        if (v.who == 1'b0) begin
            core_we    = req ? v.we : ~v.we;
            core_size  = req ? v.size : ~v.size;
            core_addr  = req ? v.addr : ~v.addr;
            core_wdata = req ? v.wdata : ~v.wdata;
            core_req   = req;
        end else begin
            dbg_we     = req ? v.we : ~v.we;
            dbg_size   = req ? v.size : ~v.size;
            dbg_addr   = req ? v.addr : ~v.addr;
            dbg_wdata  = req ? v.wdata : ~v.wdata;
            dbg_req    = req;
        end
    endtask

    // Called at a falling edge with u_dut in IDLE.
    task automatic do_txn(input int idx, input vec_t v);
        int c0;
        int en0;
        bit got;
        exp_t e;
        en0 = mem_en_cnt;
        e.who = v.who; e.err = v.exp_err; e.rdata = v.exp_rd;
        sb_q.push_back(e);
        drive_req(v, 1'b1);
        c0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (v.who ? dbg_gnt : core_gnt) got = 1'b1;
        end
        chk("gnt_seen", 32'(got), 32'd1);
        if (got) begin
            chk("gnt_latency", 32'(cyc - c0), 32'd1);
            if (v.exp_err) begin
                chk("mis_no_mem_en", 32'(mem_en), 32'd0);
                chk("mis_done_with_gnt", 32'(v.who ? dbg_done : core_done), 32'd1);
                drive_req(v, 1'b0);
            end else begin
                chk("issue_mem_en", 32'(mem_en), 32'd1);
                chk("issue_mem_we", 32'(mem_we), 32'(v.we));
                chk("issue_mem_size", 32'(mem_size), 32'(v.size));
                chk("issue_mem_addr", mem_addr, v.addr);
                chk("issue_mem_wdata", mem_wdata, v.wdata);
                drive_req(v, 1'b0);
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(negedge clk);
                    if (v.who ? dbg_done : core_done) got = 1'b1;
                end
                chk("done_seen", 32'(got), 32'd1);
                chk("done_latency", 32'(cyc - c0), 32'd3);
            end
        end else begin
            drive_req(v, 1'b0);
        end
        chk("mem_en_count", 32'(mem_en_cnt - en0), v.exp_err ? 32'd0 : 32'd1);
        $display("txn %0d who=%0d we=%0d size=%0d addr=0x%08h exp_err=%0d exp_rdata=0x%08h",
                 idx, v.who, v.we, v.size, v.addr, v.exp_err, v.exp_rd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        core_req = 1'b0; dbg_req = 1'b0; core_req3 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    // Single core access on the latency-3 instance, starting from IDLE.
    task automatic l3_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
        int cg;
        bit got;
        core_we = we; core_size = size; core_addr = addr; core_wdata = wdata;
        core_req3 = 1'b1;
        got = 1'b0;
        cg = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (core_gnt_3) got = 1'b1;
        end
        chk("l3_gnt_seen", 32'(got), 32'd1);
        cg = cyc;
        chk("l3_mem_en", 32'(mem_en_3), 32'd1);
        chk("l3_mem_we", 32'(mem_we_3), 32'(we));
        chk("l3_mem_size", 32'(mem_size_3), 32'(size));
        chk("l3_mem_addr", mem_addr_3, addr);
        chk("l3_mem_wdata", mem_wdata_3, wdata);
        core_req3 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (core_done_3) got = 1'b1;
        end
        chk("l3_done_seen", 32'(got), 32'd1);
        chk("l3_done_after_mem_en", 32'(cyc - cg), 32'd4);
        chk("l3_err", 32'(core_err_3), 32'd0);
        chk("l3_rdata", core_rdata_3, exp_rd);
        $display("l3 txn we=%0d size=%0d addr=0x%08h rdata=0x%08h", we, size, addr, core_rdata_3);
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        int last;
        bit saw;

        vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b0, 2'b10, 32'h0000_0204, 32'h0,         1'b0, mem_f(32'h204)};
        vecs[2] = '{1'b0, 1'b1, 2'b01, 32'h0000_0102, 32'h0000_1234, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b1, 2'b10, 32'h0000_0202, 32'h1111_2222, 1'b1, mem_f(32'h204)};
        vecs[4] = '{1'b0, 1'b0, 2'b01, 32'h0000_0101, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 1'b0, 2'b11, 32'h0000_0000, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{1'b1, 1'b0, 2'b00, 32'h0000_0003, 32'h0,         1'b0, mem_f(32'h3)};
        vecs[7] = '{1'b0, 1'b0, 2'b10, 32'h0000_0008, 32'h0,         1'b0, mem_f(32'h8)};

        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_size = 2'b00; core_addr = '0; core_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_size = 2'b00; dbg_addr = '0; dbg_wdata = '0;
        core_req3 = 1'b0; dbg_req3 = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pulses", 32'({core_gnt, core_done, core_err, dbg_gnt, dbg_done, dbg_err, mem_en, mem_we}), 32'd0);
        chk("rst_mem_bus", mem_addr | mem_wdata | 32'(mem_size), 32'd0);
        chk("rst_rdata", core_rdata | dbg_rdata, 32'd0);
        chk("rst_owner", 32'(owner), 32'd1);
        chk("rst_owner_3", 32'(owner_3), 32'd1);
        rst = 1'b0;

        // Single-requester vector table
        for (int i = 0; i < 8; i++) begin
            do_txn(i, vecs[i]);
        end

        // Both requesting continuously: core, dbg, core, dbg
        do_reset();
        core_we = 1'b0; core_size = 2'b10; core_addr = 32'h40;
        dbg_we = 1'b0;  dbg_size = 2'b10;  dbg_addr = 32'h80;
        core_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.who = i[0]; e.err = 1'b0;
            e.rdata = i[0] ? mem_f(32'h80) : mem_f(32'h40);
            sb_q.push_back(e);
        end
        n = 0;
        last = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (core_gnt || dbg_gnt) begin
                chk("rr_winner", 32'(dbg_gnt), 32'(n % 2));
                chk("rr_owner", 32'(owner), 32'(n % 2));
                if (n > 0) chk("rr_spacing", 32'(cyc - last), 32'd4);
                last = cyc;
                $display("rr grant %0d to %s", n, dbg_gnt ? "dbg" : "core");
                n++;
            end
        end
        core_req = 1'b0; dbg_req = 1'b0;
        chk("rr_grants", 32'(n), 32'd4);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        chk("rr_drained", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);

        // Latency 3: store then read
        l3_txn(1'b1, 2'b00, 32'h0000_0007, 32'h0000_00AB, 32'h0);
        l3_txn(1'b0, 2'b10, 32'h0000_0010, 32'h0,         mem_f(32'h10));

        // Reset during WAIT of a core read
        core_we = 1'b0; core_size = 2'b10; core_addr = 32'h20; core_req = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 20 && !saw; k++) begin
            @(negedge clk);
            if (core_gnt) saw = 1'b1;
        end
        chk("rstw_gnt_seen", 32'(saw), 32'd1);
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_pulses", 32'({core_gnt, core_done, core_err, dbg_gnt, dbg_done, dbg_err, mem_en}), 32'd0);
        chk("rstw_owner", 32'(owner), 32'd1);
        chk("rstw_rdata", core_rdata, 32'd0);
        rst = 1'b0;
        sb_q.delete();
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (core_done) saw = 1'b1;
        end
        chk("rstw_no_done", 32'(saw), 32'd0);
        begin
            vec_t v;
            v = '{1'b1, 1'b0, 2'b10, 32'h0000_0030, 32'h0, 1'b0, mem_f(32'h30)};
            do_txn(8, v);
        end

        chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
